// File: rtl/logic_unit_sched_pkg.sv
// rtl/logic_unit_sched_pkg.sv - shared types and helpers for the logic unit scheduler
//
// Purpose: FSM state encoding and the client-index width helper used by
// logic_unit_sched and rr_arbiter.
package logic_unit_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    ACCEPT = 3'd2,
    RUN    = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Width of a client index; never narrower than one bit.
  function automatic int idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick among pending clients
//
// Purpose: returns the first pending client at or after rr_ptr, wrapping
// modulo N. The pointer register lives in the parent.
// Ports:
//   pending  in  N    per-client request pending flags
//   rr_ptr   in  IDW  search start position
//   grant_id out IDW  selected client (0 when nothing pending)
//   any_req  out 1    at least one client pending
module rr_arbiter
  import logic_unit_sched_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = idw(N)
) (
  input  logic [N-1:0]   pending,
  input  logic [IDW-1:0] rr_ptr,
  output logic [IDW-1:0] grant_id,
  output logic           any_req
);

  int             pos;
  logic [IDW-1:0] idx;

  // Scan from the farthest offset down to offset 0 so the closest pending
  // client to rr_ptr is the last (winning) assignment.
  always_comb begin
    grant_id = '0;
    any_req  = |pending;
    pos      = 0;
    idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = (int'(rr_ptr) + k) % N;
      idx = IDW'(pos);
      if (pending[idx]) begin
        grant_id = idx;
      end
    end
  end

endmodule

// File: rtl/logic_unit_sched.sv
// rtl/logic_unit_sched.sv - round-robin scheduler sharing one serial logic unit
//
// Purpose: buffers one request vector per client, issues them to the shared
// unit in round-robin order, returns each result tagged with the client index,
// and turns a unit that never finishes into an error response.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready per-client handshake (ready = not pending)
//   req_data        client i owns bits [i*WIDTH +: WIDTH]
//   resp_valid/ready response handshake
//   resp_id         client index of the response
//   resp_out        unit result (0 on error)
//   resp_err        watchdog expired
//   unit_valid      one-cycle issue pulse
//   unit_req_vec    vector of the granted client
//   unit_done       unit idle/done level
//   unit_out        unit result, valid in the cycle unit_done rises
module logic_unit_sched
  import logic_unit_sched_pkg::*;
#(
  parameter  int N_CLIENTS = 4,
  parameter  int WIDTH     = 16,
  parameter  int TIMEOUT   = 64,
  localparam int IDW       = idw(N_CLIENTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CLIENTS-1:0]       req_valid,
  output logic [N_CLIENTS-1:0]       req_ready,
  input  logic [N_CLIENTS*WIDTH-1:0] req_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [IDW-1:0]             resp_id,
  output logic                       resp_out,
  output logic                       resp_err,
  output logic                       unit_valid,
  output logic [WIDTH-1:0]           unit_req_vec,
  input  logic                       unit_done,
  input  logic                       unit_out
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t               state, state_next;
  logic [N_CLIENTS-1:0] pending;
  logic [WIDTH-1:0]     req_buf [N_CLIENTS];
  logic [IDW-1:0]       rr_ptr, grant_id, arb_id;
  logic                 any_req;
  logic [WDW-1:0]       wd_cnt, wd_inc;
  logic                 wd_expire;
  logic                 res_reg, err_reg;
  logic                 grant_load, resp_hs, cap_res, cap_err;

  rr_arbiter #(.N(N_CLIENTS)) u_arb (
    .pending  (pending),
    .rr_ptr   (rr_ptr),
    .grant_id (arb_id),
    .any_req  (any_req)
  );

  assign req_ready    = ~pending;
  assign unit_req_vec = req_buf[grant_id];
  assign resp_id      = grant_id;
  assign resp_out     = res_reg;
  assign resp_err     = err_reg;

  // wd_inc is the number of cycles since ISSUE in the current cycle; it
  // saturates so a stuck FSM can never see the count wrap back to zero.
  assign wd_inc    = (wd_cnt == WDW'(TIMEOUT)) ? wd_cnt : wd_cnt + 1'b1;
  assign wd_expire = (wd_inc == WDW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unit_valid = 1'b0;
    resp_valid = 1'b0;
    grant_load = 1'b0;
    resp_hs    = 1'b0;
    cap_res    = 1'b0;
    cap_err    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && unit_done) begin
          grant_load = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        unit_valid = 1'b1;
        state_next = ACCEPT;
      end
      ACCEPT: begin
        if (wd_expire) begin
          cap_err    = 1'b1;
          state_next = RESP;
        end else if (!unit_done) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // A result arriving on the expiry cycle still wins.
        if (unit_done) begin
          cap_res    = 1'b1;
          state_next = RESP;
        end else if (wd_expire) begin
          cap_err    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          resp_hs    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
      wd_cnt   <= '0;
      res_reg  <= 1'b0;
      err_reg  <= 1'b0;
      for (int i = 0; i < N_CLIENTS; i++) begin
        req_buf[i] <= '0;
      end
    end else begin
      // A pending client is stalled, so a capture and the response clear
      // below can never target the same bit in one cycle.
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (req_valid[i] && !pending[i]) begin
          req_buf[i] <= req_data[i*WIDTH +: WIDTH];
          pending[i] <= 1'b1;
        end
      end
      if (grant_load) begin
        grant_id <= arb_id;
      end
      if (unit_valid) begin
        wd_cnt <= '0;
      end else if (state == ACCEPT || state == RUN) begin
        wd_cnt <= wd_inc;
      end
      if (cap_res) begin
        res_reg <= unit_out;
        err_reg <= 1'b0;
      end
      if (cap_err) begin
        res_reg <= 1'b0;
        err_reg <= 1'b1;
      end
      if (resp_hs) begin
        pending[grant_id] <= 1'b0;
        err_reg           <= 1'b0;
        rr_ptr            <= (grant_id == IDW'(N_CLIENTS - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_sched.sv
// tb/tb_logic_unit_sched.sv - model-checked random and directed bench for logic_unit_sched
`timescale 1ns/1ps
module tb_logic_unit_sched;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TO  = 64;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_data;
  logic           resp_valid, resp_ready;
  logic [IDW-1:0] resp_id;
  logic           resp_out, resp_err, unit_valid;
  logic           unit_done = 1'b1;
  logic           unit_out  = 1'b0;
  logic [W-1:0]   unit_req_vec;

  logic_unit_sched #(.N_CLIENTS(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_out     (resp_out),
    .resp_err     (resp_err),
    .unit_valid   (unit_valid),
    .unit_req_vec (unit_req_vec),
    .unit_done    (unit_done),
    .unit_out     (unit_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Unit operation: top bit selects OR (1) or AND (0) of the remaining bits.
  function automatic logic unit_fn(input logic [W-1:0] v);
    return v[W-1] ? |v[W-2:0] : &v[W-2:0];
  endfunction

  // Behavioural unit: done falls after accepting, rises u_cnt cycles later.
  logic u_hang  = 1'b0;
  int   u_force = -1;
  int   u_cnt   = 0;
  logic u_res   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_done <= 1'b1;
      unit_out  <= 1'b0;
      u_cnt     <= 0;
      u_res     <= 1'b0;
    end else begin
      unit_out <= 1'($urandom_range(0, 1));
      if (unit_done && unit_valid) begin
        unit_done <= 1'b0;
        u_cnt     <= (u_force > 0) ? u_force : int'($urandom_range(1, 8));
        u_res     <= unit_fn(unit_req_vec);
      end else if (!unit_done && !u_hang) begin
        if (u_cnt <= 1) begin
          unit_done <= 1'b1;
          unit_out  <= u_res;
        end else begin
          u_cnt <= u_cnt - 1;
        end
      end
    end
  end

  // Scheduler reference model, expressed as request sets and cycle counts.
  logic [N-1:0] m_pending;
  logic [W-1:0] m_data [N];
  int           m_rr, m_g, m_j;
  bit           m_busy, m_issue, m_run, m_low, m_resp, m_out, m_err;
  int           cyc = 0;
  int           issue_cyc = 0;
  int           resp_cyc = 0;
  bit           prev_rv = 1'b0;

  typedef struct {
    int id;
    bit out;
    bit err;
  } resp_t;
  resp_t log_q[$];

  function automatic int arb(input logic [N-1:0] p, input int rr);
    for (int k = 0; k < N; k++) begin
      if (p[(rr + k) % N]) return (rr + k) % N;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] acc;
    logic [N-1:0] exp_rdy;
    bit           hs;
    cyc++;
    if (rst) begin
      exp_rdy = '1;
      chk("rst_req_ready", req_ready, exp_rdy);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_unit_valid", unit_valid, 0);
      m_pending = '0;
      for (int i = 0; i < N; i++) m_data[i] = '0;
      m_rr = 0; m_g = 0; m_j = 0;
      m_busy = 0; m_issue = 0; m_run = 0; m_low = 0;
      m_resp = 0; m_out = 0; m_err = 0;
      prev_rv = 0;
    end else begin
      exp_rdy = ~m_pending;
      chk("req_ready", req_ready, exp_rdy);
      chk("unit_valid", unit_valid, m_issue);
      chk("unit_req_vec", unit_req_vec, m_data[m_g]);
      chk("resp_valid", resp_valid, m_resp);
      if (m_resp) begin
        chk("resp_id", resp_id, m_g);
        chk("resp_out", resp_out, m_out);
        chk("resp_err", resp_err, m_err);
      end
      if (unit_valid) issue_cyc = cyc;
      if (resp_valid && !prev_rv) resp_cyc = cyc;
      prev_rv = resp_valid;
      if (resp_valid && resp_ready) log_q.push_back(resp_t'{int'(resp_id), resp_out, resp_err});

      hs  = m_resp && resp_ready;
      acc = req_valid & ~m_pending;

      if (m_issue) begin
        m_issue = 0; m_run = 1; m_j = 0; m_low = 0;
      end else if (m_run) begin
        m_j++;
        if (m_low && unit_done) begin
          m_run = 0; m_resp = 1; m_out = unit_fn(m_data[m_g]); m_err = 0;
        end else if (m_j >= TO) begin
          m_run = 0; m_resp = 1; m_out = 0; m_err = 1;
        end
        if (!unit_done) m_low = 1;
      end

      if (!m_busy && (|m_pending) && unit_done) begin
        m_g = arb(m_pending, m_rr); m_busy = 1; m_issue = 1;
      end

      if (hs) begin
        m_pending[m_g] = 1'b0; m_rr = (m_g + 1) % N; m_resp = 0; m_busy = 0;
      end

      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          m_pending[i] = 1'b1;
          m_data[i]    = req_data[i*W +: W];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [W-1:0] d);
    req_valid[i]       = 1'b1;
    req_data[i*W +: W] = d;
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic burst();
    req_data  = {$urandom(), $urandom()};
    req_valid = '1;
    tick();
    req_valid = '0;
  endtask

  task automatic wait_log(input int n);
    for (int k = 0; k < 3000 && log_q.size() < n; k++) tick();
    chk("resp_count", log_q.size(), n);
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && !(req_ready == '1 && !resp_valid && unit_done); k++) tick();
    chk("drain_ready", req_ready, 4'hF);
  endtask

  task automatic order4(input int a, input int b, input int c, input int d);
    chk("order0", log_q[0].id, a);
    chk("order1", log_q[1].id, b);
    chk("order2", log_q[2].id, c);
    chk("order3", log_q[3].id, d);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // Single requests
    log_q.delete();
    send(2, 16'h8001);
    wait_log(1);
    chk("single_id", log_q[0].id, 2);
    chk("single_out", log_q[0].out, 1);
    chk("single_err", log_q[0].err, 0);
    send(1, 16'h8000);
    wait_log(2);
    chk("single2_id", log_q[1].id, 1);
    chk("single2_out", log_q[1].out, 0);
    send(3, 16'h7FFF);
    wait_log(3);
    chk("single3_id", log_q[2].id, 3);
    chk("single3_out", log_q[2].out, 1);

    // Bursts: pointer at 0 twice, then after serving only client 1
    drain(); log_q.delete(); burst(); wait_log(4); order4(0, 1, 2, 3);
    drain(); log_q.delete(); burst(); wait_log(4); order4(0, 1, 2, 3);
    drain(); log_q.delete(); send(1, 16'h8001); wait_log(1);
    log_q.delete(); burst(); wait_log(4); order4(2, 3, 0, 1);

    // Backpressure: response held 10 cycles while other clients load
    drain(); log_q.delete();
    resp_ready = 1'b0;
    send(0, 16'h8003);
    for (int k = 0; k < 200 && !resp_valid; k++) tick();
    chk("bp_resp_valid", resp_valid, 1);
    send(2, 16'h0123);
    send(3, 16'hFFFF);
    repeat (8) tick();
    chk("bp_req_ready", req_ready, 4'b0010);
    chk("bp_resp_id", resp_id, 0);
    chk("bp_resp_out", resp_out, 1);
    resp_ready = 1'b1;
    wait_log(3);
    chk("bp_order0", log_q[0].id, 0);
    chk("bp_order1", log_q[1].id, 2);
    chk("bp_order2", log_q[2].id, 3);
    chk("bp_out3", log_q[2].out, 1);

    // Hung unit, then the next client after the unit recovers
    drain(); log_q.delete();
    u_hang = 1'b1;
    send(1, 16'h8001);
    send(2, 16'h8010);
    wait_log(1);
    u_hang = 1'b0;
    chk("to_id", log_q[0].id, 1);
    chk("to_err", log_q[0].err, 1);
    chk("to_out", log_q[0].out, 0);
    chk("to_latency", resp_cyc - issue_cyc, TO + 1);
    wait_log(2);
    chk("to_next_id", log_q[1].id, 2);
    chk("to_next_err", log_q[1].err, 0);
    chk("to_next_out", log_q[1].out, 1);

    // Result arriving on the last allowed cycle vs one cycle late
    drain(); log_q.delete();
    u_force = TO - 1;
    send(0, 16'h8001);
    wait_log(1);
    chk("edge_err", log_q[0].err, 0);
    chk("edge_out", log_q[0].out, 1);
    chk("edge_latency", resp_cyc - issue_cyc, TO + 1);
    drain();
    u_force = TO;
    send(0, 16'h8001);
    wait_log(2);
    chk("late_err", log_q[1].err, 1);
    chk("late_out", log_q[1].out, 0);

    // Reset while the unit is running
    drain();
    u_force = 20;
    send(2, 16'h8001);
    for (int k = 0; k < 200 && !unit_valid; k++) tick();
    chk("rst_issue_seen", unit_valid, 1);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", req_ready, 4'hF);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_unit_valid", unit_valid, 0);
    chk("arst_resp_id", resp_id, 0);
    chk("arst_resp_out", resp_out, 0);
    chk("arst_resp_err", resp_err, 0);
    chk("arst_unit_req_vec", unit_req_vec, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    u_force = -1;
    tick();

    // Client 0 requests continuously after reset
    log_q.delete();
    req_data  = {16'hFFFF, 16'h0F0F, 16'h8002, 16'h8001};
    req_valid = '1;
    tick();
    req_valid = 4'b0001;
    wait_log(6);
    order4(0, 1, 2, 3);
    chk("hold_id4", log_q[4].id, 0);
    chk("hold_id5", log_q[5].id, 0);
    chk("hold_out0", log_q[0].out, 1);
    chk("hold_out2", log_q[2].out, 0);
    req_valid = '0;
    drain();

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 3) == 0);
      req_data = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) req_data[$urandom_range(0, N - 1) * W +: W - 1] = '1;
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
